// File: rtl/dl_mem_writer.sv
// -----------------------------------------------------------------------------
// dl_mem_writer
//
// Buffers single-cycle byte writes from the SPI download receiver and commits
// them, one at a time, to the 16-bit SDRAM controller port over a req/ack
// handshake. A small FIFO absorbs bursts while the SDRAM port is stalled. The
// block holds the CPU in reset for the whole download and pulses dl_done only
// after every buffered byte has been acknowledged.
//
// Ports:
//   clk, reset_n   system clock; asynchronous active-low reset
//   downloading    download-active level from the receiver
//   dl_wr          one-cycle byte write strobe
//   dl_addr[24:0]  byte address
//   dl_data[7:0]   byte data
//   mem_req        write request to the SDRAM port (held until mem_ack)
//   mem_ack        one-cycle acknowledge from the SDRAM port
//   mem_addr[23:0] word address (dl_addr[24:1])
//   mem_din[15:0]  byte replicated into both lanes
//   mem_be[1:0]    lane enable: 2'b01 even byte, 2'b10 odd byte
//   cpu_hold       keep the CPU in reset
//   dl_done        one-cycle pulse when the download has fully completed
//   overflow       sticky: a byte was dropped because the FIFO was full
//   byte_cnt[24:0] bytes acknowledged in the current download
//   checksum[15:0] wrapping sum of acknowledged bytes (DL_CHECKSUM_EN only)
//
// Build option: define DL_CHECKSUM_EN to add the checksum port and adder.
// -----------------------------------------------------------------------------
module dl_mem_writer #(
  parameter int DEPTH = 4  // power of two, 2..16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        downloading,
  input  logic        dl_wr,
  input  logic [24:0] dl_addr,
  input  logic [7:0]  dl_data,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [23:0] mem_addr,
  output logic [15:0] mem_din,
  output logic [1:0]  mem_be,
  output logic        cpu_hold,
  output logic        dl_done,
  output logic        overflow,
  output logic [24:0] byte_cnt
`ifdef DL_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_INC = (AW + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DRAIN
  } state_e;

  state_e      state_q, state_d;

  // FIFO entry layout: {byte address[24:0], data[7:0]}
  logic [32:0] fifo_mem [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        fifo_full, fifo_empty;
  logic        push, pop, drop, start, hold_clr;
  logic [32:0] head, load_entry;

  logic        dl_prev_q;
  logic        mem_req_q, mem_req_d;
  logic [23:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_din_q, mem_din_d;
  logic [1:0]  mem_be_q, mem_be_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        overflow_q, overflow_d;
  logic [24:0] byte_cnt_q, byte_cnt_d;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign start = downloading && !dl_prev_q;
  assign pop   = (state_q == ST_WAIT) && mem_ack;
  // When full, a same-cycle pop frees the slot being written; the head it
  // overwrites has already been copied into the output registers.
  assign push  = dl_wr && (!fifo_full || pop);
  assign drop  = dl_wr && fifo_full && !pop;

  assign head = fifo_mem[rd_ptr_q[AW-1:0]];
  // With an empty FIFO the incoming byte bypasses straight to the outputs so
  // the request appears the cycle after the strobe. It is still pushed and is
  // popped normally on its ack.
  assign load_entry = fifo_empty ? {dl_addr, dl_data} : head;

  // NOTE: the storage array has no reset; emptiness is defined by the reset
  // pointers alone, so clearing the data would only cost logic.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= {dl_addr, dl_data};
  end

  // NOTE: every always_comb assigns all of its outputs a default first so a
  // branch that does not mention a signal cannot infer a latch.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_be_d   = mem_be_q;
    hold_clr   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty || dl_wr) begin
          mem_req_d  = 1'b1;
          mem_addr_d = load_entry[32:9];
          mem_din_d  = {load_entry[7:0], load_entry[7:0]};
          mem_be_d   = load_entry[8] ? 2'b10 : 2'b01;
          state_d    = ST_WAIT;
        end else if (!downloading && cpu_hold_q) begin
          state_d = ST_DRAIN;
        end
      end
      ST_WAIT: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        hold_clr = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A start edge wins over a coincident ack: the acked byte is not counted.
  // A new start also wins over a coincident drain so the CPU stays held.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    overflow_d = overflow_q;
    cpu_hold_d = cpu_hold_q;
    if (start)         byte_cnt_d = '0;
    else if (pop)      byte_cnt_d = byte_cnt_q + 25'd1;
    if (start)         overflow_d = 1'b0;
    if (drop)          overflow_d = 1'b1;
    if (hold_clr)      cpu_hold_d = 1'b0;
    if (start)         cpu_hold_d = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      dl_prev_q  <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_be_q   <= '0;
      cpu_hold_q <= 1'b0;
      overflow_q <= 1'b0;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_INC;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_INC;
      dl_prev_q  <= downloading;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_be_q   <= mem_be_d;
      cpu_hold_q <= cpu_hold_d;
      overflow_q <= overflow_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

`ifdef DL_CHECKSUM_EN
  logic [15:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (start)    checksum_d = '0;
    else if (pop) checksum_d = checksum_q + {8'd0, mem_din_q[7:0]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) checksum_q <= '0;
    else          checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`endif

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_be   = mem_be_q;
  assign cpu_hold = cpu_hold_q;
  assign overflow = overflow_q;
  assign byte_cnt = byte_cnt_q;
  assign dl_done  = (state_q == ST_DRAIN);

endmodule

// File: tb/tb_dl_mem_writer.sv
// -----------------------------------------------------------------------------
// tb_dl_mem_writer
//
// Directed testbench for dl_mem_writer (DEPTH = 4). Inputs are driven 1 ns
// after the rising edge and outputs are sampled at that same point, well away
// from the next active edge. Checksum comparisons exist only when the bench
// is built with DL_CHECKSUM_EN, matching the design.
// -----------------------------------------------------------------------------
module tb_dl_mem_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        downloading;
  logic        dl_wr;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic        mem_req;
  logic        mem_ack;
  logic [23:0] mem_addr;
  logic [15:0] mem_din;
  logic [1:0]  mem_be;
  logic        cpu_hold;
  logic        dl_done;
  logic        overflow;
  logic [24:0] byte_cnt;
`ifdef DL_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  always #5 clk = ~clk;

  dl_mem_writer #(.DEPTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .downloading(downloading),
    .dl_wr      (dl_wr),
    .dl_addr    (dl_addr),
    .dl_data    (dl_data),
    .mem_req    (mem_req),
    .mem_ack    (mem_ack),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_be     (mem_be),
    .cpu_hold   (cpu_hold),
    .dl_done    (dl_done),
    .overflow   (overflow),
    .byte_cnt   (byte_cnt)
`ifdef DL_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  // Counts every cycle in which dl_done is high.
  always @(negedge clk) begin
    if (dl_done === 1'b1) done_cnt = done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    downloading = 1'b0;
    dl_wr       = 1'b0;
    mem_ack     = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // One-cycle write strobe.
  task automatic strobe(input logic [24:0] a, input logic [7:0] d);
    dl_wr   = 1'b1;
    dl_addr = a;
    dl_data = d;
    tick();
    dl_wr = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (mem_req !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check({tag, " req"}, {31'd0, mem_req}, 32'd1);
  endtask

  // Waits for a request, holds off the ack for waitc cycles, checks the
  // presented word and then acknowledges it.
  task automatic ack_after(input int waitc, input logic [23:0] ea,
                           input logic [15:0] ed, input logic [1:0] eb,
                           input string tag);
    wait_req(tag);
    repeat (waitc) tick();
    check({tag, " addr"}, {8'd0, mem_addr}, {8'd0, ea});
    check({tag, " din"}, {16'd0, mem_din}, {16'd0, ed});
    check({tag, " be"}, {30'd0, mem_be}, {30'd0, eb});
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check({tag, " req low after ack"}, {31'd0, mem_req}, 32'd0);
  endtask

  task automatic expect_quiet(input string tag);
    int reqs = 0;
    repeat (5) begin
      if (mem_req === 1'b1) reqs++;
      tick();
    end
    check(tag, reqs, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int first;
    int n;

    reset_n     = 1'b0;
    downloading = 1'b0;
    dl_wr       = 1'b0;
    dl_addr     = '0;
    dl_data     = '0;
    mem_ack     = 1'b0;

    // ---------------- reset state ----------------
    tick();
    check("rst mem_req", {31'd0, mem_req}, 32'd0);
    check("rst cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check("rst overflow", {31'd0, overflow}, 32'd0);
    check("rst dl_done", {31'd0, dl_done}, 32'd0);
    check("rst byte_cnt", {7'd0, byte_cnt}, 32'd0);
    check("rst mem_addr", {8'd0, mem_addr}, 32'd0);
    check("rst mem_din", {16'd0, mem_din}, 32'd0);
    check("rst mem_be", {30'd0, mem_be}, 32'd0);
    reset_n = 1'b1;
    tick();

    // ---------------- basic write ----------------
    downloading = 1'b1;
    tick();
    check("t1 cpu_hold set", {31'd0, cpu_hold}, 32'd1);
    strobe(25'h100001, 8'hA5);
    check("t1 req latency", {31'd0, mem_req}, 32'd1);
    check("t1 mem_addr", {8'd0, mem_addr}, 32'h080000);
    check("t1 mem_be", {30'd0, mem_be}, 32'd2);
    check("t1 mem_din", {16'd0, mem_din}, 32'hA5A5);
    repeat (3) tick();
    check("t1 req held", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("t1 req dropped", {31'd0, mem_req}, 32'd0);
    check("t1 byte_cnt", {7'd0, byte_cnt}, 32'd1);
`ifdef DL_CHECKSUM_EN
    check("t1 checksum", {16'd0, checksum}, 32'h00A5);
`endif

    // ---------------- back-pressure / overflow ----------------
    do_reset();
    downloading = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) strobe(25'(32'h10 + 2 * i), 8'(i + 1));
    check("t2 overflow", {31'd0, overflow}, 32'd1);
    repeat (20) tick();
    check("t2 req stalled", {31'd0, mem_req}, 32'd1);
    check("t2 byte_cnt stalled", {7'd0, byte_cnt}, 32'd0);
    for (int i = 0; i < 4; i++)
      ack_after(0, 24'(32'h8 + i), 16'((i + 1) * 257), 2'b01, $sformatf("t2 e%0d", i));
    expect_quiet("t2 dropped byte not sent");
    check("t2 byte_cnt", {7'd0, byte_cnt}, 32'd4);
    check("t2 overflow sticky", {31'd0, overflow}, 32'd1);
`ifdef DL_CHECKSUM_EN
    check("t2 checksum", {16'd0, checksum}, 32'd10);
`endif

    // ---------------- full push/pop ----------------
    do_reset();
    downloading = 1'b1;
    tick();
    strobe(25'h201, 8'h11);
    strobe(25'h203, 8'h22);
    strobe(25'h205, 8'h33);
    strobe(25'h207, 8'h44);
    check("t3 req before pushpop", {31'd0, mem_req}, 32'd1);
    dl_wr   = 1'b1;
    dl_addr = 25'h209;
    dl_data = 8'h55;
    mem_ack = 1'b1;
    tick();
    dl_wr   = 1'b0;
    mem_ack = 1'b0;
    check("t3 overflow clear", {31'd0, overflow}, 32'd0);
    check("t3 byte_cnt after pop", {7'd0, byte_cnt}, 32'd1);
    ack_after(0, 24'h101, 16'h2222, 2'b10, "t3 e1");
    ack_after(0, 24'h102, 16'h3333, 2'b10, "t3 e2");
    ack_after(0, 24'h103, 16'h4444, 2'b10, "t3 e3");
    ack_after(0, 24'h104, 16'h5555, 2'b10, "t3 e4");
    expect_quiet("t3 fifo drained");
    check("t3 byte_cnt", {7'd0, byte_cnt}, 32'd5);
    check("t3 overflow still clear", {31'd0, overflow}, 32'd0);

    // ---------------- completion ----------------
    do_reset();
    downloading = 1'b1;
    tick();
    base = done_cnt;
    strobe(25'h300, 8'h01);
    strobe(25'h302, 8'h02);
    downloading = 1'b0;
    ack_after(5, 24'h180, 16'h0101, 2'b01, "t4 e0");
    check("t4 no done after first ack", done_cnt - base, 0);
    check("t4 hold after first ack", {31'd0, cpu_hold}, 32'd1);
    ack_after(5, 24'h181, 16'h0202, 2'b01, "t4 e1");
    first = 0;
    for (int k = 1; k <= 6; k++) begin
      if (first == 0 && dl_done === 1'b1) first = k;
      if (first == 0) check("t4 hold before done", {31'd0, cpu_hold}, 32'd1);
      tick();
    end
    check("t4 done latency in window", {31'd0, (first >= 1 && first <= 3)}, 32'd1);
    check("t4 done pulse count", done_cnt - base, 1);
    check("t4 hold released", {31'd0, cpu_hold}, 32'd0);
    check("t4 byte_cnt", {7'd0, byte_cnt}, 32'd2);

    // ---------------- reset mid-request ----------------
    do_reset();
    downloading = 1'b1;
    tick();
    strobe(25'h400, 8'h77);
    check("t5 req before reset", {31'd0, mem_req}, 32'd1);
    #2;
    reset_n     = 1'b0;
    downloading = 1'b0;
    #1;
    check("t5 req async clear", {31'd0, mem_req}, 32'd0);
    check("t5 hold async clear", {31'd0, cpu_hold}, 32'd0);
    check("t5 addr async clear", {8'd0, mem_addr}, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("t5 stray ack byte_cnt", {7'd0, byte_cnt}, 32'd0);
    expect_quiet("t5 abandoned request");

    // ---------------- wrap and restart ----------------
    do_reset();
    downloading = 1'b1;
    tick();
    for (int i = 0; i < 256; i++) begin
      strobe(25'(i), 8'hFF);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
    end
    check("t6 byte_cnt", {7'd0, byte_cnt}, 32'd256);
`ifdef DL_CHECKSUM_EN
    check("t6 checksum", {16'd0, checksum}, 32'hFF00);
`endif
    base = done_cnt;
    downloading = 1'b0;
    n = 0;
    while (dl_done !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check("t6 done seen", {31'd0, dl_done}, 32'd1);
    tick();
    check("t6 done count", done_cnt - base, 1);
    check("t6 byte_cnt kept after done", {7'd0, byte_cnt}, 32'd256);
    // A write outside a download is still committed and does not hold the CPU.
    strobe(25'h500, 8'h12);
    check("t6 idle write req", {31'd0, mem_req}, 32'd1);
    check("t6 idle write no hold", {31'd0, cpu_hold}, 32'd0);
    // New download edge coincides with the ack: counters clear, byte not counted.
    downloading = 1'b1;
    mem_ack     = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("t6 restart byte_cnt", {7'd0, byte_cnt}, 32'd0);
    check("t6 restart hold", {31'd0, cpu_hold}, 32'd1);
    check("t6 restart overflow", {31'd0, overflow}, 32'd0);
`ifdef DL_CHECKSUM_EN
    check("t6 restart checksum", {16'd0, checksum}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
